// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver: double-buffered frame capture with tear-free
// swaps at frame boundaries and a blanking gap before every lit row.
module led_matrix_scan #(
   parameter int ROWS  = 6,
   parameter int COLS  = 6,
   parameter int DWELL = 5000,
   parameter int BLANK = 50
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [ROWS*COLS-1:0] frame_in,
   input  logic                 frame_valid,
   output logic                 frame_ack,
   output logic                 frame_start,
   output logic [ROWS-1:0]      row_sel,
   output logic [COLS-1:0]      col_data,
   output logic [2:0]           db_row,
   output logic [1:0]           db_state
);

   localparam int MAX_CNT = (BLANK > DWELL) ? BLANK : DWELL;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW      = ROWS * COLS;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               boundary;

   logic [FW-1:0]      shadow_q, shadow_d;
   logic [FW-1:0]      buffer_q, buffer_d;
   logic               pending_q, pending_d;
   logic               frame_ack_q, frame_ack_d;
   logic               frame_start_q, frame_start_d;
   logic [ROWS-1:0]    row_sel_q, row_sel_d;
   logic [COLS-1:0]    col_data_q, col_data_d;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
         row_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d  = S_BLANK;
               row_d    = '0;
               cnt_d    = '0;
               boundary = 1'b1;
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  if (row_q == ROW_LAST) begin
                     row_d    = '0;
                     boundary = 1'b1;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               row_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Swap uses the old shadow; a capture on the same edge refills it and keeps pending set.
   always_comb begin
      shadow_d    = shadow_q;
      buffer_d    = buffer_q;
      pending_d   = pending_q;
      frame_ack_d = 1'b0;
      if (boundary && pending_q) begin
         buffer_d    = shadow_q;
         pending_d   = 1'b0;
         frame_ack_d = 1'b1;
      end
      if (frame_valid) begin
         shadow_d  = frame_in;
         pending_d = 1'b1;
      end
   end

   // Outputs are decoded from next-state values so the registered drive lines up with state_q.
   always_comb begin
      row_sel_d     = '0;
      col_data_d    = '0;
      frame_start_d = boundary;
      if (state_d == S_SHOW) begin
         row_sel_d  = ROWS'(1) << row_d;
         col_data_d = buffer_d[row_d*COLS +: COLS];
      end
   end

   // NOTE: the frame stores are reset so the matrix shows a blank frame after reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q      <= '0;
         buffer_q      <= '0;
         pending_q     <= 1'b0;
         frame_ack_q   <= 1'b0;
         frame_start_q <= 1'b0;
         row_sel_q     <= '0;
         col_data_q    <= '0;
      end else begin
         shadow_q      <= shadow_d;
         buffer_q      <= buffer_d;
         pending_q     <= pending_d;
         frame_ack_q   <= frame_ack_d;
         frame_start_q <= frame_start_d;
         row_sel_q     <= row_sel_d;
         col_data_q    <= col_data_d;
      end
   end

   assign frame_ack   = frame_ack_q;
   assign frame_start = frame_start_q;
   assign row_sel     = row_sel_q;
   assign col_data    = col_data_q;
   assign db_row      = 3'(row_q);
   assign db_state    = state_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: a frame-position model pushes expected outputs each
// edge, a monitor pops and compares them; directed checks cover the key events.
module tb_led_matrix_scan;

   localparam int ROWS   = 6;
   localparam int COLS   = 6;
   localparam int DWELL  = 4;
   localparam int BLANK  = 2;
   localparam int SLOT   = BLANK + DWELL;
   localparam int PERIOD = ROWS * SLOT;

   logic                 clock;
   logic                 reset_n;
   logic                 enable;
   logic [ROWS*COLS-1:0] frame_in;
   logic                 frame_valid;
   logic                 frame_ack;
   logic                 frame_start;
   logic [ROWS-1:0]      row_sel;
   logic [COLS-1:0]      col_data;
   logic [2:0]           db_row;
   logic [1:0]           db_state;

   led_matrix_scan #(
      .ROWS (ROWS),
      .COLS (COLS),
      .DWELL(DWELL),
      .BLANK(BLANK)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .frame_in   (frame_in),
      .frame_valid(frame_valid),
      .frame_ack  (frame_ack),
      .frame_start(frame_start),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .db_row     (db_row),
      .db_state   (db_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic            ack;
      logic            start;
      logic [ROWS-1:0] rsel;
      logic [COLS-1:0] col;
      logic [2:0]      row;
      logic [1:0]      st;
   } obs_t;

   obs_t expq[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Reference model: tracks position within the frame rather than row/counter state.
   logic                 m_on;
   int                   m_pos;
   logic [ROWS*COLS-1:0] m_shadow;
   logic [ROWS*COLS-1:0] m_buf;
   logic                 m_pend;
   logic                 m_bnd;
   int                   m_row;
   int                   m_ph;
   obs_t                 m_e;

   always @(posedge clock) begin
      m_e = '0;
      if (!reset_n) begin
         m_on     = 1'b0;
         m_pos    = 0;
         m_shadow = '0;
         m_buf    = '0;
         m_pend   = 1'b0;
      end else begin
         if (!enable) begin
            m_on  = 1'b0;
            m_pos = 0;
         end else begin
            m_bnd = !m_on || (m_pos == PERIOD - 1);
            m_pos = m_bnd ? 0 : m_pos + 1;
            if (m_bnd && m_pend) begin
               m_buf    = m_shadow;
               m_pend   = 1'b0;
               m_e.ack  = 1'b1;
            end
            m_e.start = m_bnd;
            m_on      = 1'b1;
         end
         if (frame_valid) begin
            m_shadow = frame_in;
            m_pend   = 1'b1;
         end
         if (m_on) begin
            m_row    = m_pos / SLOT;
            m_ph     = m_pos % SLOT;
            m_e.row  = 3'(m_row);
            if (m_ph < BLANK) begin
               m_e.st = 2'd1;
            end else begin
               m_e.st   = 2'd2;
               m_e.rsel = ROWS'(1) << m_row;
               m_e.col  = m_buf[m_row*COLS +: COLS];
            end
         end
      end
      expq.push_back(m_e);
   end

   obs_t mon_exp;
   obs_t mon_got;

   always @(posedge clock) begin
      #1;
      check("q_size", 64'(expq.size()), 64'd1);
      if (expq.size() != 0) begin
         mon_exp = expq.pop_front();
         mon_got = {frame_ack, frame_start, row_sel, col_data, db_row, db_state};
         check("cycle", 64'(mon_got), 64'(mon_exp));
      end
   end

   task automatic wait_for(input int r, input int st);
      int n = 0;
      while (!(db_row == 3'(r) && db_state == 2'(st)) && n < 200) begin
         step(1);
         n++;
      end
      check("wait_row_timeout", 64'(n < 200), 64'd1);
   endtask

   task automatic wait_start();
      int n = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      check("wait_start_timeout", 64'(n < 200), 64'd1);
   endtask

   task automatic measure_period();
      int n = 0;
      wait_start();
      do begin
         step(1);
         n++;
      end while (frame_start !== 1'b1 && n < 200);
      check("period", 64'(n), 64'(PERIOD));
   endtask

   logic [ROWS*COLS-1:0] frame_b;

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b0;
      frame_valid = 1'b1;
      frame_in    = {$urandom(), $urandom()} & {ROWS*COLS{1'b1}};
      frame_b     = 36'hA_5A5A_5A5A;

      // Reset and idle hold
      step(3);
      check("rst_row_sel", 64'(row_sel), 64'd0);
      check("rst_col_data", 64'(col_data), 64'd0);
      check("rst_ack", 64'(frame_ack), 64'd0);
      check("rst_state", 64'(db_state), 64'd0);
      frame_valid = 1'b0;
      reset_n     = 1'b1;
      step(10);
      check("idle_hold", 64'(db_state), 64'd0);

      // Basic scan
      frame_in    = 36'h8_0000_0001;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
      enable      = 1'b1;
      step(1);
      check("t2_start", 64'(frame_start), 64'd1);
      check("t2_ack", 64'(frame_ack), 64'd1);
      step(2);
      check("t2_row0_sel", 64'(row_sel), 64'h01);
      check("t2_row0_col", 64'(col_data), 64'h01);
      wait_for(5, 2);
      check("t2_row5_sel", 64'(row_sel), 64'h20);
      check("t2_row5_col", 64'(col_data), 64'h20);
      measure_period();

      // Tear-free update presented mid-row 2
      wait_for(2, 2);
      frame_in    = 36'hF_FFFF_FFFF;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
      wait_for(5, 2);
      check("t3_old_row5", 64'(col_data), 64'h20);
      wait_start();
      check("t3_ack_with_start", 64'(frame_ack), 64'd1);
      wait_for(0, 2);
      check("t3_new_row0", 64'(col_data), 64'h3F);

      // Capture coinciding with the swap edge
      wait_start();
      frame_in    = 36'h1_2345_6789;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
      step(PERIOD - 2);
      frame_in    = frame_b;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
      check("t4_swap1_start", 64'(frame_start), 64'd1);
      check("t4_swap1_ack", 64'(frame_ack), 64'd1);
      step(PERIOD);
      check("t4_swap2_start", 64'(frame_start), 64'd1);
      check("t4_swap2_ack", 64'(frame_ack), 64'd1);
      step(PERIOD);
      check("t4_swap3_start", 64'(frame_start), 64'd1);
      check("t4_swap3_ack", 64'(frame_ack), 64'd0);

      // Enable drop during row 3
      wait_for(3, 2);
      enable = 1'b0;
      step(1);
      check("t5_dark_state", 64'(db_state), 64'd0);
      check("t5_dark_rows", 64'(row_sel), 64'd0);
      step(3);
      enable = 1'b1;
      step(1);
      check("t5_restart", 64'(frame_start), 64'd1);
      step(2);
      check("t5_row0_sel", 64'(row_sel), 64'h01);
      check("t5_row0_col", 64'(col_data), 64'(frame_b[COLS-1:0]));

      // Asynchronous reset mid-row 4 with a frame pending
      frame_in    = 36'h3_C3C3_C3C3;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
      wait_for(4, 2);
      #3;
      reset_n = 1'b0;
      #1;
      check("t6_async_rows", 64'(row_sel), 64'd0);
      check("t6_async_cols", 64'(col_data), 64'd0);
      step(2);
      reset_n = 1'b1;
      step(1);
      check("t6_restart", 64'(frame_start), 64'd1);
      check("t6_no_ack", 64'(frame_ack), 64'd0);
      step(PERIOD + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
